// File: rtl/rv32ima_pkg.sv
// Shared types for the RAM arbiter: response states, word type, width codes,
// arbiter FSM states and byte-lane helpers.
package rv32ima_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RAM_FREE  = 2'd0,
    RAM_ADDR  = 2'd1,
    RAM_DATA  = 2'd2,
    RAM_ERROR = 2'd3
  } ram_state_t;

  typedef enum logic [1:0] {
    WIDTH_BYTE = 2'b00,
    WIDTH_HALF = 2'b01,
    WIDTH_WORD = 2'b10,
    WIDTH_BAD  = 2'b11
  } ram_width_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_RESP
  } arb_state_t;

  // Lane mask for a naturally aligned access of the given width.
  function automatic logic [3:0] byte_enable(input logic [1:0] width, input logic [1:0] lsb);
    case (ram_width_t'(width))
      WIDTH_BYTE: byte_enable = 4'b0001 << lsb;
      WIDTH_HALF: byte_enable = 4'b0011 << {lsb[1], 1'b0};
      WIDTH_WORD: byte_enable = 4'b1111;
      default:    byte_enable = 4'b0000;
    endcase
  endfunction

  // Alignment fault for the given width; the reserved width code always faults.
  function automatic logic misaligned(input logic [1:0] width, input logic [1:0] lsb);
    case (ram_width_t'(width))
      WIDTH_BYTE: misaligned = 1'b0;
      WIDTH_HALF: misaligned = lsb[0];
      WIDTH_WORD: misaligned = (lsb != 2'b00);
      default:    misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ram_array.sv
// Single-port-write / single-port-read word array with byte enables and a
// registered read. Contents are never reset.
module ram_array #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane write and read-before-write registered read.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ram_arb_ctrl.sv
// Round-robin arbiter for NPORTS requesters sharing one word RAM. One access
// in flight: grant (write commits) -> LAT wait cycles -> one response cycle.
module ram_arb_ctrl
  import rv32ima_pkg::*;
#(
  parameter int NPORTS       = 2,
  parameter int DEPTH_WORDS  = 1024,
  parameter int LAT          = 0,
  parameter int REORDER_DATA = 0
) (
  input  logic                    ram_clk,
  input  logic                    rst,
  input  logic [NPORTS-1:0]       req_wen,
  input  logic [NPORTS-1:0]       req_ren,
  input  logic [NPORTS-1:0][31:0] req_addr,
  input  logic [NPORTS-1:0][1:0]  req_width,
  input  logic [NPORTS-1:0][31:0] req_store,
  output ram_state_t [NPORTS-1:0] resp_state,
  output logic [NPORTS-1:0][31:0] resp_load
);

  localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

  arb_state_t    state;
  logic [3:0]    cnt;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt;
  logic [AW-1:0] l_word;

  logic [NPORTS-1:0] act;
  logic [NPORTS-1:0] err;
  logic [NPORTS-1:0] valid;
  logic              found;
  logic [IW-1:0]     sel;
  logic              wr_en;
  logic [3:0]        be;
  logic [AW-1:0]     raddr;
  word_t             rdata;
  word_t             rd_fmt;

  // Classify each requester: active, faulting, or eligible for grant.
  always_comb begin
    act   = '0;
    err   = '0;
    valid = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      act[i]   = req_wen[i] | req_ren[i];
      err[i]   = act[i] & ((req_wen[i] & req_ren[i])
                 | misaligned(req_width[i], req_addr[i][1:0])
                 | ({2'b00, req_addr[i][31:2]} >= DEPTH_L));
      valid[i] = act[i] & ~err[i];
    end
  end

  // Round-robin search starting one past the last granted port.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int unsigned k = 1; k <= NPORTS; k++) begin
      if (!found && valid[IW'((32'(ptr) + k) % NPORTS)]) begin
        found = 1'b1;
        sel   = IW'((32'(ptr) + k) % NPORTS);
      end
    end
  end

  // Write commits on the grant edge straight from the live request, so the
  // store data and width need not be retained; only the word index is kept
  // for the reads issued during the wait cycles.
  always_comb begin
    wr_en = (state == ARB_IDLE) && found && !rst && req_wen[sel];
    be    = byte_enable(req_width[sel], req_addr[sel][1:0]);
    raddr = (state == ARB_IDLE) ? req_addr[sel][AW+1:2] : l_word;
  end

  ram_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (ram_clk),
    .we   (wr_en),
    .be   (be),
    .waddr(req_addr[sel][AW+1:2]),
    .wdata(req_store[sel]),
    .raddr(raddr),
    .rdata(rdata)
  );

  // Arbiter FSM: grant in IDLE, count LAT cycles in BUSY, one RESP cycle.
  always_ff @(posedge ram_clk or posedge rst) begin
    if (rst) begin
      state  <= ARB_IDLE;
      cnt    <= '0;
      ptr    <= IW'(NPORTS - 1);
      gnt    <= '0;
      l_word <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (found) begin
            gnt    <= sel;
            ptr    <= sel;
            l_word <= req_addr[sel][AW+1:2];
            if (LAT == 0) begin
              state <= ARB_RESP;
            end else begin
              cnt   <= 4'(LAT - 1);
              state <= ARB_BUSY;
            end
          end
        end
        ARB_BUSY: begin
          if (cnt == '0) state <= ARB_RESP;
          else           cnt   <= cnt - 4'd1;
        end
        ARB_RESP: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

  // Optional byte swap of the read word.
  always_comb begin
    if (REORDER_DATA != 0) rd_fmt = {rdata[7:0], rdata[15:8], rdata[23:16], rdata[31:24]};
    else                   rd_fmt = rdata;
  end

  // Per-port status; the in-flight port is reported even if it dropped its request.
  always_comb begin
    for (int unsigned i = 0; i < NPORTS; i++) begin
      resp_load[i] = 32'hdeadbeef;
      if (state == ARB_RESP && gnt == IW'(i)) begin
        resp_state[i] = RAM_DATA;
        resp_load[i]  = rd_fmt;
      end else if (state == ARB_BUSY && gnt == IW'(i)) begin
        resp_state[i] = RAM_ADDR;
      end else if (!act[i]) begin
        resp_state[i] = RAM_FREE;
      end else if (err[i]) begin
        resp_state[i] = RAM_ERROR;
      end else begin
        resp_state[i] = RAM_ADDR;
      end
    end
  end

endmodule

// File: doc/ram_arb_ctrl.md
RAM_ARB_CTRL -- requirements
Module: ram_arb_ctrl

Interface
REQ-001 SHALL have parameter NPORTS, default 2: number of requester channels (1..4).
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words in the array (power of two).
REQ-003 SHALL have parameter LAT, default 0: extra wait cycles per access (0..15).
REQ-004 SHALL have parameter REORDER_DATA, default 0: when 1, byte-swap read data {b0,b1,b2,b3}.
REQ-005 SHALL have port ram_clk, input, 1: the only clock (already decided).
REQ-006 SHALL have port rst, input, 1: asynchronous active-high reset (already decided).
REQ-007 SHALL have port req_wen, input, NPORTS: per-port write request.
REQ-008 SHALL have port req_ren, input, NPORTS: per-port read request.
REQ-009 SHALL have port req_addr, input, NPORTS x 32: per-port byte address.
REQ-010 SHALL have port req_width, input, NPORTS x 2: 00 byte, 01 half, 10 word.
REQ-011 SHALL have port req_store, input, NPORTS x 32: per-port write data, naturally lane-aligned.
REQ-012 SHALL have port resp_state, output, NPORTS x ram_state_t: per-port RAM_FREE/RAM_ADDR/RAM_DATA/RAM_ERROR.
REQ-013 SHALL have port resp_load, output, NPORTS x 32: per-port read word, 32'hdeadbeef when not RAM_DATA.

Function
REQ-014 SHALL run FSM IDLE -> BUSY -> RESP -> IDLE, one transaction in flight.
REQ-015 SHALL, per port: no wen/ren -> RAM_FREE; wen&ren, misaligned, or word index >= DEPTH_WORDS -> RAM_ERROR; valid waiting or in-flight -> RAM_ADDR; selected port in RESP -> RAM_DATA.
REQ-016 SHALL treat as misaligned: half with addr[0]=1; word with addr[1:0]!=0; width 11.
REQ-017 SHALL, in IDLE, grant round-robin among valid requesters, starting at index after last granted (port 0 first after reset).
REQ-018 SHALL never grant a RAM_ERROR requester; error ports are not counted and do not move the pointer.
REQ-019 SHALL latch grant index, address, width, store data at grant edge and commit writes at that edge under byte enable.
REQ-020 SHALL set byte enable: byte 4'b1<<addr[1:0], half 4'b11<<{addr[1],0}, word 4'b1111.
REQ-021 SHALL spend exactly LAT cycles in BUSY (LAT=0 goes directly to RESP); RAM_DATA appears LAT+1 cycles after grant edge.
REQ-022 SHALL hold RESP one cycle only; next grant earliest on the RESP->IDLE edge, giving LAT+2 cycles per access.
REQ-023 SHALL return full read word (reordered if REORDER_DATA) on resp_load of the granted port only; writes also report RAM_DATA.
REQ-024 SHALL complete an in-flight transaction even if requester drops wen/ren; response shown regardless.
REQ-025 SHALL return pre-write data for a read granted the cycle after a write to same word? No: writes commit before the next grant, so reads always see prior writes.

Reset
REQ-026 SHALL on rst: FSM IDLE, BUSY counter 0, grant pointer to port NPORTS-1 (so port 0 wins first), latched request cleared.
REQ-027 SHALL while rst high drive resp_load 32'hdeadbeef and resp_state by REQ-015 combinational rules but no RAM_DATA.
REQ-028 SHALL abort an in-flight transaction on rst; a write already committed remains, array contents are not cleared.

Structure
REQ-029 SHALL take ram_state_t, word_t, width encodings from rv32ima_pkg; add ram_width_t there.
REQ-030 SHALL instantiate one sub-module ram_array (DEPTH_WORDS x 32, byte-enabled write, synchronous read).

Verification
REQ-031 Port0 read word @0x10, LAT=3, mem=0x11223344 -> RAM_ADDR 4 cycles, RAM_DATA cycle 4, load 0x11223344 (0x44332211 with REORDER_DATA).
REQ-032 Port1 store byte 0xAB @0x13 over 0 -> byteen 1000; port1 reads 0x13 -> 0xAB000000.
REQ-033 Ports 0,1 continuous reads LAT=0 -> grants alternate 0,1,0,1, one RAM_DATA every 2 cycles.
REQ-034 Port0 half @0x21 -> RAM_ERROR, never granted; port1 valid request same cycle granted normally.
REQ-035 Port0 wen&ren -> RAM_ERROR; port1 address 4*DEPTH_WORDS -> RAM_ERROR; no array change.
REQ-036 rst asserted mid-BUSY after write -> IDLE, no RAM_DATA; read-back after reset returns written value.
